// File: rtl/axis_pkg.sv
// Shared AXI4-Stream definitions: default widths, packet FSM encoding and a byte-sum helper.
package axis_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned DEPTH_DEFAULT  = 8;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StInPkt = 1'b1
    } pkt_state_e;

    // Mod-256 accumulate; the carry out is intentionally dropped.
    function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/axis_rx_mem.sv
// Receive buffer storage: register array with one synchronous write port and one async read port.
module axis_rx_mem #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are deliberately not reset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_rx_buffer.sv
// AXI4-Stream receive FIFO (first-word fall-through) with per-packet byte sum and packet counter.
module axis_rx_buffer
    import axis_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              rd_valid,
    output logic [AW:0]       level,
    output logic              pkt_done,
    output logic [7:0]        pkt_sum,
    output logic [7:0]        pkt_count,
    output logic              underflow
);

    localparam logic [AW:0] PtrOne  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FullLvl = {1'b1, {AW{1'b0}}};

    logic [AW:0]     wptr_q, rptr_q;
    logic            ready_en_q;
    pkt_state_e      state_q;
    logic [7:0]      sum_q;
    logic [7:0]      byte8;
    logic [7:0]      sum_next;
    logic            push, pop;
    logic [DATA_W:0] mem_rdata;

    // Occupancy and handshake decode only from registered pointers.
    assign level    = wptr_q - rptr_q;
    assign rd_valid = (level != '0);
    assign s_tready = ready_en_q && (level != FullLvl);

    assign push = s_tvalid && s_tready;
    assign pop  = rd_en && rd_valid;

    axis_rx_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr_q[AW-1:0]),
        .wdata ({s_tlast, s_tdata}),
        .raddr (rptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    assign rd_data = mem_rdata[DATA_W-1:0];
    assign rd_last = mem_rdata[DATA_W];

    // Holds s_tready low for the first cycle after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PtrOne;
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrOne;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            underflow <= 1'b0;
        end else if (rd_en && !rd_valid) begin
            underflow <= 1'b1;
        end
    end

    assign byte8    = 8'(s_tdata);
    assign sum_next = sum_add((state_q == StIdle) ? 8'h00 : sum_q, byte8);

    // Packet accounting follows accepted input only; reads never affect it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            sum_q     <= 8'h00;
            pkt_done  <= 1'b0;
            pkt_sum   <= 8'h00;
            pkt_count <= 8'h00;
        end else begin
            pkt_done <= 1'b0;
            if (push) begin
                if (s_tlast) begin
                    state_q   <= StIdle;
                    sum_q     <= 8'h00;
                    pkt_done  <= 1'b1;
                    pkt_sum   <= sum_next;
                    pkt_count <= pkt_count + 8'd1;
                end else begin
                    state_q <= StInPkt;
                    sum_q   <= sum_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_rx_buffer.sv
// Directed self-checking bench for axis_rx_buffer.
module tb_axis_rx_buffer;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tready;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       rd_valid;
    logic [3:0] level;
    logic       pkt_done;
    logic [7:0] pkt_sum;
    logic [7:0] pkt_count;
    logic       underflow;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q[$];
    logic [8:0] head;

    always #5 clk = ~clk;

    axis_rx_buffer #(
        .DATA_W (8),
        .DEPTH  (8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .rd_valid  (rd_valid),
        .level     (level),
        .pkt_done  (pkt_done),
        .pkt_sum   (pkt_sum),
        .pkt_count (pkt_count),
        .underflow (underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 8'h00;
        rd_en    = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        chk("ready_low_at_release", s_tready, 0);
        tick();
        chk("ready_after_release", s_tready, 1);
    endtask

    initial begin
        resetn   = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 8'h00;
        rd_en    = 1'b0;
        #2;
        chk("rst_level", level, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_pkt_sum", pkt_sum, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_underflow", underflow, 0);
        do_reset();

        // Three-byte packet with no reads.
        s_tvalid = 1'b1; s_tdata = 8'h01; s_tlast = 1'b0;
        tick();
        chk("p1_level1", level, 1);
        chk("p1_head", rd_data, 8'h01);
        s_tdata = 8'h02;
        tick();
        chk("p1_level2", level, 2);
        chk("p1_no_done", pkt_done, 0);
        s_tdata = 8'h03; s_tlast = 1'b1;
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        chk("p1_level3", level, 3);
        chk("p1_done", pkt_done, 1);
        chk("p1_sum", pkt_sum, 8'h06);
        chk("p1_count", pkt_count, 1);
        tick();
        chk("p1_done_pulse", pkt_done, 0);
        chk("p1_sum_hold", pkt_sum, 8'h06);

        rd_en = 1'b1;
        chk("p1_rd0", rd_data, 8'h01);
        chk("p1_rd0_last", rd_last, 0);
        tick();
        chk("p1_rd1", rd_data, 8'h02);
        tick();
        chk("p1_rd2", rd_data, 8'h03);
        chk("p1_rd2_last", rd_last, 1);
        tick();
        rd_en = 1'b0;
        chk("p1_empty_level", level, 0);
        chk("p1_empty_valid", rd_valid, 0);
        chk("p1_no_underflow", underflow, 0);

        // Fill to full; ninth byte held; simultaneous pop at full must not push.
        s_tvalid = 1'b1; s_tlast = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_tdata = 8'hA0 + 8'(i);
            tick();
        end
        chk("full_level", level, 8);
        chk("full_tready", s_tready, 0);
        s_tdata = 8'hA8; s_tlast = 1'b1;
        tick();
        chk("full_held_level", level, 8);
        chk("full_held_no_done", pkt_done, 0);
        rd_en = 1'b1;
        chk("full_head", rd_data, 8'hA0);
        tick();
        rd_en = 1'b0;
        chk("pop_at_full_level", level, 7);
        chk("pop_at_full_tready", s_tready, 1);
        chk("pop_at_full_no_done", pkt_done, 0);
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        chk("ninth_level", level, 8);
        chk("ninth_done", pkt_done, 1);
        chk("ninth_sum", pkt_sum, 8'hC4);
        chk("ninth_count", pkt_count, 2);

        rd_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_to4", rd_data, 8'hA0 + 8'(i));
            tick();
        end
        rd_en = 1'b0;
        chk("level_4", level, 4);

        // Steady push+pop at level 4 across pointer wrap.
        exp_q = '{9'h0A5, 9'h0A6, 9'h0A7, 9'h1A8};
        s_tvalid = 1'b1; rd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_tdata = 8'h30 + 8'(i);
            s_tlast = (i == 19);
            head = exp_q.pop_front();
            chk("stream_data", rd_data, head[7:0]);
            chk("stream_last", rd_last, head[8]);
            exp_q.push_back({s_tlast, s_tdata});
            tick();
            chk("stream_level", level, 4);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; rd_en = 1'b0;
        chk("stream_done", pkt_done, 1);
        chk("stream_sum", pkt_sum, 8'h7E);
        chk("stream_count", pkt_count, 3);

        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            head = exp_q.pop_front();
            chk("stream_tail", rd_data, head[7:0]);
            tick();
        end
        rd_en = 1'b0;
        chk("stream_drained", level, 0);

        // Read while empty.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("uf_set", underflow, 1);
        chk("uf_level", level, 0);
        tick();
        tick();
        chk("uf_sticky", underflow, 1);
        chk("uf_level_hold", level, 0);

        // Wrapping sum and a one-byte packet after a fresh reset.
        do_reset();
        chk("rst2_underflow", underflow, 0);
        chk("rst2_count", pkt_count, 0);
        s_tvalid = 1'b1; s_tdata = 8'hFF; s_tlast = 1'b0;
        tick();
        s_tlast = 1'b1;
        tick();
        chk("ff_done", pkt_done, 1);
        chk("ff_sum", pkt_sum, 8'hFE);
        chk("ff_count", pkt_count, 1);
        s_tdata = 8'h7F;
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        chk("one_done", pkt_done, 1);
        chk("one_sum", pkt_sum, 8'h7F);
        chk("one_count", pkt_count, 2);
        chk("one_level", level, 3);

        // Reset in the middle of a packet.
        do_reset();
        s_tvalid = 1'b1; s_tdata = 8'h11; s_tlast = 1'b0;
        tick();
        s_tdata = 8'h22;
        tick();
        chk("mid_level", level, 2);
        resetn = 1'b0;
        #1;
        s_tvalid = 1'b0;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", rd_valid, 0);
        chk("mid_rst_tready", s_tready, 0);
        chk("mid_rst_done", pkt_done, 0);
        chk("mid_rst_sum", pkt_sum, 0);
        chk("mid_rst_count", pkt_count, 0);
        tick();
        resetn = 1'b1;
        tick();
        chk("mid_rel_tready", s_tready, 1);
        chk("mid_rel_no_done", pkt_done, 0);
        s_tvalid = 1'b1; s_tdata = 8'h10; s_tlast = 1'b1;
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        chk("post_done", pkt_done, 1);
        chk("post_sum", pkt_sum, 8'h10);
        chk("post_count", pkt_count, 1);
        chk("post_level", level, 1);
        chk("post_head", rd_data, 8'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
